fifo_wr_controller: RTL and testbench
=====================================

FIFO_WR_CONTROLLER -- requirements
Module: fifo_wr_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample and FIFO data width.
REQ-002 SHALL have parameter LEN_W, default 8, capture-length field width; fixed at 8 because the length field is din[15:8].
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port din, input, 32: SPI control word.
REQ-006 SHALL have port wclk, input, 1: SPI write strobe; din is valid while high.
REQ-007 SHALL have port trig, input, 1: asynchronous capture trigger, level-sensitive.
REQ-008 SHALL have port sample_valid, input, 1: sample_data is valid this cycle.
REQ-009 SHALL have port sample_data, input, DATA_W: acquisition sample.
REQ-010 SHALL have port fifo_full, input, 1: FIFO full flag from the write side.
REQ-011 SHALL have port fifo_we, output, 1: FIFO write-enable pulse, one clk wide.
REQ-012 SHALL have port fifo_din, output, DATA_W: data written to FIFO.
REQ-013 SHALL have port overflow_alarm, output, 1: sticky flag, set when a sample is dropped.
REQ-014 SHALL have port drop_count, output, 8: count of dropped samples, saturating.
REQ-015 SHALL have port state, output, 2: current FSM state, for SPI readback.
REQ-016 SHALL have port done, output, 1: high while in STOPPED.

Function
REQ-017 SHALL decode a control write on each clk rising edge where wclk=1; each control command SHALL take effect once per wclk rising edge (wclk high for N cycles = one command).
REQ-018 Control-word bit assignment SHALL be: din[0]=arm, din[1]=stop, din[16]=clear, din[15:8]=capture length L (0 = unlimited).
REQ-019 FSM states SHALL be encoded IDLE=0, ARMED=1, CAPTURE=2, STOPPED=3.
REQ-020 IDLE->ARMED on arm: latch L and zero the written-sample counter.
REQ-021 ARMED->CAPTURE when synchronised trig=1; trig SHALL pass through a 2-FF synchroniser (2-3 cycle latency).
REQ-022 CAPTURE->STOPPED when the written count reaches L (L!=0), or on stop.
REQ-023 STOPPED->ARMED on arm; stop in ARMED SHALL go to IDLE.
REQ-024 clear SHALL force IDLE and clear overflow_alarm and drop_count, with priority over arm/stop in the same write.
REQ-025 In CAPTURE, sample_valid=1 with fifo_full=0 SHALL assert fifo_we on the next cycle with fifo_din=sample_data (latency 1) and increment the written count.
REQ-026 In CAPTURE, sample_valid=1 with fifo_full=1 SHALL drop the sample: no fifo_we, overflow_alarm<=1, drop_count+1 saturating at 255; the written count SHALL NOT increment.
REQ-027 sample_valid outside CAPTURE SHALL be ignored, with no alarm.
REQ-028 The sample that makes the count equal L SHALL be written and SHALL be the last; samples on the STOPPED transition cycle SHALL be ignored.
REQ-029 stop and a valid sample in the same cycle: the sample SHALL be written, then the FSM SHALL enter STOPPED.
REQ-030 fifo_din SHALL hold its last value when fifo_we=0.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state=IDLE, fifo_we=0, fifo_din=0, overflow_alarm=0, drop_count=0, done=0, latched L=0, count=0, synchroniser=0, wclk edge register=0.
REQ-032 Reset asserted mid-capture SHALL abort with no further fifo_we; deassertion SHALL require a new arm.

Configuration
REQ-033 The macro FIFO_WR_DROP_CNT_EN SHALL control the drop counter.
REQ-034 With FIFO_WR_DROP_CNT_EN defined, drop_count SHALL be implemented per REQ-026.
REQ-035 Without FIFO_WR_DROP_CNT_EN, drop_count SHALL be constant 0 and no counter logic SHALL be present; overflow_alarm SHALL be unaffected.

Verification
REQ-036 Scenario: arm with L=4, trig=1, 6 consecutive valid samples 0x0001..0x0006 -> exactly 4 fifo_we pulses with data 0x0001..0x0004, then state=3 and done=1.
REQ-037 Scenario: in CAPTURE, fifo_full=1 during 3 valid samples -> 0 writes, overflow_alarm=1, drop_count=3; after fifo_full=0 writes resume and the alarm stays 1.
REQ-038 Scenario: 300 dropped samples -> drop_count=255; then a write with din[16]=1 -> drop_count=0, overflow_alarm=0, state=0.
REQ-039 Scenario: arm with L=0 and trig held low -> state=1 and no writes; trig=1 -> CAPTURE within 3 cycles; stop -> STOPPED.
REQ-040 Scenario: rst_n low for 1 cycle mid-capture -> fifo_we=0 immediately, all outputs 0, state=0.
REQ-041 Scenario: wclk held high for 5 cycles with din[0]=1 from STOPPED -> a single ARMED entry with the count cleared once.

Source files
------------

// File: rtl/fifo_wr_controller.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_controller
// Purpose  : SPI-controlled capture FSM that forwards acquisition samples into
//            a FIFO, stops after a programmed length, and tracks overflow.
//            Optional macro FIFO_WR_DROP_CNT_EN enables the saturating
//            dropped-sample counter; without it drop_count is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_controller #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       din,
  input  logic              wclk,
  input  logic              trig,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              fifo_full,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_din,
  output logic              overflow_alarm,
  output logic [7:0]        drop_count,
  output logic [1:0]        state,
  output logic              done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] STOPPED = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cnt_inc;
  logic              fifo_we_q, fifo_we_d;
  logic [DATA_W-1:0] fifo_din_q, fifo_din_d;
  logic              alarm_q, alarm_d;
  logic              wclk_q;
  logic              trig_s1_q, trig_s2_q;

  logic              cmd_fire;
  logic              cmd_arm;
  logic              cmd_stop;
  logic              cmd_clear;
  logic              capturing;
  logic              sample_drop;

  // Control bits that carry no meaning are folded away here.
  logic              unused_din;
  assign unused_din = ^{din[31:17], din[7:2]};

  // A command is decoded only on the first cycle of a wclk high pulse.
  assign cmd_fire  = wclk & ~wclk_q;
  assign cmd_arm   = cmd_fire & din[0];
  assign cmd_stop  = cmd_fire & din[1];
  assign cmd_clear = cmd_fire & din[16];

  // A clear aborts the capture in the same cycle, so its sample is not taken.
  assign capturing   = (state_q == CAPTURE) && !cmd_clear;
  assign sample_drop = capturing && sample_valid && fifo_full;
  assign cnt_inc     = cnt_q + 1'b1;

  // Next-state, sample forwarding and alarm logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    fifo_we_d  = 1'b0;
    fifo_din_d = fifo_din_q;
    alarm_d    = alarm_q;

    if (capturing && sample_valid) begin
      if (!fifo_full) begin
        fifo_we_d  = 1'b1;
        fifo_din_d = sample_data;
        cnt_d      = cnt_inc;
        // The sample reaching the programmed length is the last one written.
        if ((len_q != '0) && (cnt_inc == len_q)) begin
          state_d = STOPPED;
        end
      end else begin
        alarm_d = 1'b1;
      end
    end

    if (cmd_clear) begin
      state_d = IDLE;
      alarm_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_arm) begin
            state_d = ARMED;
            len_d   = din[8 +: LEN_W];
            cnt_d   = '0;
          end
        end
        ARMED: begin
          if (cmd_stop) begin
            state_d = IDLE;
          end else if (trig_s2_q) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          // A sample arriving with stop is still written above.
          if (cmd_stop) begin
            state_d = STOPPED;
          end
        end
        STOPPED: begin
          if (cmd_arm) begin
            state_d = ARMED;
            len_d   = din[8 +: LEN_W];
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, datapath, synchroniser and wclk edge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      fifo_we_q  <= 1'b0;
      fifo_din_q <= '0;
      alarm_q    <= 1'b0;
      wclk_q     <= 1'b0;
      trig_s1_q  <= 1'b0;
      trig_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      fifo_we_q  <= fifo_we_d;
      fifo_din_q <= fifo_din_d;
      alarm_q    <= alarm_d;
      wclk_q     <= wclk;
      trig_s1_q  <= trig;
      trig_s2_q  <= trig_s1_q;
    end
  end

`ifdef FIFO_WR_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of samples lost to a full FIFO.
  always_comb begin
    drop_d = drop_q;
    if (cmd_clear) begin
      drop_d = '0;
    end else if (sample_drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  logic unused_drop;
  assign unused_drop = sample_drop;
  assign drop_count  = 8'd0;
`endif

  assign fifo_we        = fifo_we_q;
  assign fifo_din       = fifo_din_q;
  assign overflow_alarm = alarm_q;
  assign state          = state_q;
  assign done           = (state_q == STOPPED);

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_controller
// Purpose  : Directed scenarios for fifo_wr_controller; expected FIFO writes
//            are queued by the stimulus and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        wclk = 1'b0;
  logic        trig = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_we;
  logic [15:0] fifo_din;
  logic        overflow_alarm;
  logic [7:0]  drop_count;
  logic [1:0]  state;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

`ifdef FIFO_WR_DROP_CNT_EN
  localparam logic [7:0] DROP3   = 8'd3;
  localparam logic [7:0] DROPSAT = 8'd255;
`else
  localparam logic [7:0] DROP3   = 8'd0;
  localparam logic [7:0] DROPSAT = 8'd0;
`endif

  fifo_wr_controller #(.DATA_W(16), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wclk(wclk), .trig(trig),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_din(fifo_din),
    .overflow_alarm(overflow_alarm), .drop_count(drop_count),
    .state(state), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  // Scoreboard monitor: every FIFO write must match the oldest expected word.
  always @(negedge clk) begin
    if (fifo_we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL fifo_write: got unexpected write 0x%04h, expected none", fifo_din);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (fifo_din !== e) begin
          miscompares++;
          $display("FAIL fifo_write: got 0x%04h, expected 0x%04h", fifo_din, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_cmd(input logic [31:0] w, input int hold);
    din  = w;
    wclk = 1'b1;
    tick(hold);
    wclk = 1'b0;
    din  = '0;
    tick(1);
  endtask

  task automatic send(input logic [15:0] d, input bit expect_wr);
    sample_valid = 1'b1;
    sample_data  = d;
    if (expect_wr) exp_q.push_back(d);
    tick(1);
  endtask

  initial begin
    // Reset values
    tick(2);
    check("rst_state", state, 2'd0);
    check("rst_we", fifo_we, 1'b0);
    check("rst_din", fifo_din, 16'h0);
    check("rst_alarm", overflow_alarm, 1'b0);
    check("rst_drop", drop_count, 8'd0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick(1);

    // Length-4 capture: six samples offered, first four written
    write_cmd(32'h0000_0401, 1);
    check("arm_l4_state", state, 2'd1);
    trig = 1'b1;
    tick(3);
    check("l4_capture", state, 2'd2);
    for (int i = 1; i <= 6; i++) send(16'(i), i <= 4);
    sample_valid = 1'b0;
    tick(2);
    check("l4_stopped", state, 2'd3);
    check("l4_done", done, 1'b1);

    // Re-arm held for five cycles from STOPPED, then a length-2 capture
    trig = 1'b0;
    tick(3);
    write_cmd(32'h0000_0201, 5);
    check("hold_arm_state", state, 2'd1);
    trig = 1'b1;
    tick(3);
    check("l2_capture", state, 2'd2);
    send(16'h0010, 1'b1);
    send(16'h0011, 1'b1);
    send(16'h0012, 1'b0);
    sample_valid = 1'b0;
    tick(2);
    check("l2_stopped", state, 2'd3);

    // Unlimited length, trigger synchroniser latency, stop with a sample
    trig = 1'b0;
    tick(3);
    write_cmd(32'h0000_0001, 1);
    tick(5);
    check("l0_armed_wait", state, 2'd1);
    trig = 1'b1;
    tick(2);
    check("sync_latency2", state, 2'd1);
    tick(1);
    check("sync_latency3", state, 2'd2);
    send(16'h0020, 1'b1);
    send(16'h0021, 1'b1);
    send(16'h0022, 1'b1);
    sample_valid = 1'b1;
    sample_data  = 16'h0A0A;
    exp_q.push_back(16'h0A0A);
    din  = 32'h0000_0002;
    wclk = 1'b1;
    tick(1);
    wclk = 1'b0;
    din  = '0;
    sample_valid = 1'b0;
    tick(1);
    check("stop_state", state, 2'd3);
    check("stop_done", done, 1'b1);

    // Overflow: three drops, then writes resume with the alarm kept
    write_cmd(32'h0000_0001, 1);
    check("ovf_capture", state, 2'd2);
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) send(16'h0030 + 16'(i), 1'b0);
    sample_valid = 1'b0;
    tick(1);
    check("ovf_alarm", overflow_alarm, 1'b1);
    check("ovf_drop3", drop_count, DROP3);
    fifo_full = 1'b0;
    send(16'h0033, 1'b1);
    send(16'h0034, 1'b1);
    sample_valid = 1'b0;
    tick(3);
    check("ovf_alarm_sticky", overflow_alarm, 1'b1);
    check("din_hold", fifo_din, 16'h0034);
    check("we_idle", fifo_we, 1'b0);

    // Saturation and clear
    fifo_full = 1'b1;
    for (int i = 0; i < 300; i++) send(16'hBEEF, 1'b0);
    sample_valid = 1'b0;
    tick(1);
    check("drop_sat", drop_count, DROPSAT);
    fifo_full = 1'b0;
    write_cmd(32'h0001_0000, 1);
    check("clr_drop", drop_count, 8'd0);
    check("clr_alarm", overflow_alarm, 1'b0);
    check("clr_state", state, 2'd0);

    // Samples outside CAPTURE are ignored
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0050, 1'b0);
    fifo_full = 1'b0;
    for (int i = 0; i < 2; i++) send(16'h0051, 1'b0);
    sample_valid = 1'b0;
    tick(1);
    check("idle_no_alarm", overflow_alarm, 1'b0);

    // Reset mid-capture
    write_cmd(32'h0000_0001, 1);
    tick(1);
    check("rstcap_state", state, 2'd2);
    fifo_full = 1'b1;
    send(16'h003F, 1'b0);
    fifo_full = 1'b0;
    send(16'h0040, 1'b1);
    send(16'h0041, 1'b1);
    #2;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("mid_rst_we", fifo_we, 1'b0);
    check("mid_rst_din", fifo_din, 16'h0);
    check("mid_rst_alarm", overflow_alarm, 1'b0);
    check("mid_rst_drop", drop_count, 8'd0);
    check("mid_rst_state", state, 2'd0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0060, 1'b0);
    send(16'h0061, 1'b0);
    send(16'h0062, 1'b0);
    sample_valid = 1'b0;
    tick(1);
    check("post_rst_state", state, 2'd0);
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
